// File: rtl/sweep_direction_controller.sv
// Sequences an up/down counter through repeated MIN->MAX->MIN sweeps with a
// programmable dwell at each end, counting completed sweeps until a target or Stop.
module sweep_direction_controller #(
   parameter int DWELL_CYCLES      = 2,
   parameter int DWELL_WIDTH       = 8,
   parameter int SWEEP_COUNT_WIDTH = 8
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         Start,
   input  logic                         Stop,
   input  logic [SWEEP_COUNT_WIDTH-1:0] SweepTarget,
   input  logic                         LimitReachedFlag,
   output logic                         UpDownMode,
   output logic                         CounterReset,
   output logic                         Busy,
   output logic [SWEEP_COUNT_WIDTH-1:0] SweepsDone,
   output logic                         Done
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RISE,
      DWELL_HIGH,
      FALL,
      DWELL_LOW
   } state_t;

   localparam bit HAS_DWELL = (DWELL_CYCLES > 0);
   localparam logic [DWELL_WIDTH-1:0] DWELL_LOAD =
      HAS_DWELL ? DWELL_WIDTH'(DWELL_CYCLES - 1) : '0;

   state_t                         state, state_nxt;
   logic                           mode_nxt, crst_nxt, busy_nxt, done_nxt;
   logic [SWEEP_COUNT_WIDTH-1:0]   sweeps_nxt, sweeps_inc;
   logic                           armed, armed_nxt;
   logic [DWELL_WIDTH-1:0]         dwell_cnt, dwell_nxt;
   logic [SWEEP_COUNT_WIDTH-1:0]   target, target_nxt;
   logic                           limit;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state        <= IDLE;
         UpDownMode   <= 1'b0;
         CounterReset <= 1'b1;
         Busy         <= 1'b0;
         SweepsDone   <= '0;
         Done         <= 1'b0;
         armed        <= 1'b0;
         dwell_cnt    <= '0;
         target       <= '0;
      end else begin
         state        <= state_nxt;
         UpDownMode   <= mode_nxt;
         CounterReset <= crst_nxt;
         Busy         <= busy_nxt;
         SweepsDone   <= sweeps_nxt;
         Done         <= done_nxt;
         armed        <= armed_nxt;
         dwell_cnt    <= dwell_nxt;
         target       <= target_nxt;
      end
   end

   // The counter's flag stays high for one cycle after a direction change;
   // armed only rises once a low flag has been seen in the current direction.
   assign limit      = armed & LimitReachedFlag;
   assign sweeps_inc = SweepsDone + 1'b1;

   // NOTE: every next-state signal gets a default before the case so no path
   // leaves one unassigned, which would infer a latch.
   always_comb begin
      state_nxt  = state;
      mode_nxt   = UpDownMode;
      crst_nxt   = CounterReset;
      busy_nxt   = Busy;
      sweeps_nxt = SweepsDone;
      done_nxt   = 1'b0;
      armed_nxt  = armed;
      dwell_nxt  = dwell_cnt;
      target_nxt = target;

      if (state != IDLE && Stop) begin
         state_nxt = IDLE;
         crst_nxt  = 1'b1;
         mode_nxt  = 1'b0;
         busy_nxt  = 1'b0;
      end else begin
         case (state)
            IDLE: begin
               crst_nxt = 1'b1;
               mode_nxt = 1'b0;
               if (Start && !Stop) begin
                  target_nxt = SweepTarget;
                  sweeps_nxt = '0;
                  busy_nxt   = 1'b1;
                  state_nxt  = CLEAR;
               end
            end
            CLEAR: begin
               state_nxt = RISE;
               crst_nxt  = 1'b0;
               mode_nxt  = 1'b1;
               armed_nxt = 1'b0;
            end
            RISE: begin
               if (!LimitReachedFlag) armed_nxt = 1'b1;
               if (limit) begin
                  if (HAS_DWELL) begin
                     dwell_nxt = DWELL_LOAD;
                     state_nxt = DWELL_HIGH;
                  end else begin
                     state_nxt = FALL;
                     mode_nxt  = 1'b0;
                     armed_nxt = 1'b0;
                  end
               end
            end
            DWELL_HIGH: begin
               if (dwell_cnt == '0) begin
                  state_nxt = FALL;
                  mode_nxt  = 1'b0;
                  armed_nxt = 1'b0;
               end else begin
                  dwell_nxt = dwell_cnt - 1'b1;
               end
            end
            FALL: begin
               if (!LimitReachedFlag) armed_nxt = 1'b1;
               if (limit) begin
                  sweeps_nxt = sweeps_inc;
                  if (target != '0 && sweeps_inc == target) begin
                     state_nxt = IDLE;
                     done_nxt  = 1'b1;
                     busy_nxt  = 1'b0;
                     crst_nxt  = 1'b1;
                     mode_nxt  = 1'b0;
                  end else if (HAS_DWELL) begin
                     dwell_nxt = DWELL_LOAD;
                     state_nxt = DWELL_LOW;
                  end else begin
                     state_nxt = RISE;
                     mode_nxt  = 1'b1;
                     armed_nxt = 1'b0;
                  end
               end
            end
            DWELL_LOW: begin
               if (dwell_cnt == '0) begin
                  state_nxt = RISE;
                  mode_nxt  = 1'b1;
                  armed_nxt = 1'b0;
               end else begin
                  dwell_nxt = dwell_cnt - 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sweep_direction_controller.sv
// Drives two controllers (dwell 2 and dwell 0) each against a 4-bit up/down
// counter model, comparing every cycle with a sweep-level reference model.
module tb_sweep_direction_controller;

   localparam int PH_IDLE   = 0;
   localparam int PH_CLEAR  = 1;
   localparam int PH_TRAVEL = 2;
   localparam int PH_DWELL  = 3;

   typedef struct {
      int         phase;
      int         dwell_left;
      logic       up;
      logic       crst;
      logic       busy;
      logic       done;
      logic       seen_low;
      logic [7:0] sd;
      logic [7:0] target;
   } mstate_t;

   logic       Clk;
   logic       Reset;
   logic       Start;
   logic       Stop;
   logic [7:0] SweepTarget;

   int n_checks = 0;
   int n_fail   = 0;

   function automatic mstate_t model_reset();
      mstate_t n;
      n.phase = PH_IDLE; n.dwell_left = 0; n.up = 1'b0; n.crst = 1'b1;
      n.busy = 1'b0; n.done = 1'b0; n.seen_low = 1'b0; n.sd = 8'd0; n.target = 8'd0;
      return n;
   endfunction

   // One clock of sweep behaviour: travel until a genuine limit, dwell, reverse.
   function automatic mstate_t model_step(input mstate_t s, input int dwell,
                                          input logic start, input logic stop,
                                          input logic [7:0] tgt, input logic flag);
      mstate_t n;
      logic    hit;
      n = s;
      n.done = 1'b0;
      if (s.phase == PH_IDLE) begin
         n.crst = 1'b1;
         n.up   = 1'b0;
         if (start && !stop) begin
            n.target = tgt; n.sd = 8'd0; n.busy = 1'b1; n.phase = PH_CLEAR;
         end
      end else if (stop) begin
         n.phase = PH_IDLE; n.crst = 1'b1; n.up = 1'b0; n.busy = 1'b0;
      end else if (s.phase == PH_CLEAR) begin
         n.phase = PH_TRAVEL; n.crst = 1'b0; n.up = 1'b1; n.seen_low = 1'b0;
      end else if (s.phase == PH_TRAVEL) begin
         hit = s.seen_low && flag;
         if (!flag) n.seen_low = 1'b1;
         if (hit) begin
            if (!s.up) begin
               n.sd = s.sd + 8'd1;
               if (s.target != 8'd0 && n.sd == s.target) begin
                  n.done = 1'b1; n.busy = 1'b0; n.crst = 1'b1; n.up = 1'b0;
                  n.phase = PH_IDLE;
                  return n;
               end
            end
            if (dwell > 0) begin
               n.phase = PH_DWELL; n.dwell_left = dwell;
            end else begin
               n.up = !s.up; n.seen_low = 1'b0;
            end
         end
      end else begin
         n.dwell_left = s.dwell_left - 1;
         if (n.dwell_left == 0) begin
            n.up = !s.up; n.seen_low = 1'b0; n.phase = PH_TRAVEL;
         end
      end
      return n;
   endfunction

   for (genvar g = 0; g < 2; g++) begin : lane
      localparam int D = (g == 0) ? 2 : 0;
      logic       udm, crst, busy, done, flag;
      logic [7:0] sd;
      logic [3:0] cnt;
      mstate_t    m;

      sweep_direction_controller #(
         .DWELL_CYCLES(D), .DWELL_WIDTH(8), .SWEEP_COUNT_WIDTH(8)
      ) dut (
         .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop),
         .SweepTarget(SweepTarget), .LimitReachedFlag(flag),
         .UpDownMode(udm), .CounterReset(crst), .Busy(busy),
         .SweepsDone(sd), .Done(done)
      );

      // Saturating 0..15 counter; flag set while holding at the end in the current direction.
      always @(posedge Clk or posedge crst) begin
         if (crst) begin
            cnt  <= 4'd0;
            flag <= 1'b0;
         end else if (udm) begin
            if (cnt == 4'd15) flag <= 1'b1;
            else begin cnt <= cnt + 4'd1; flag <= 1'b0; end
         end else begin
            if (cnt == 4'd0) flag <= 1'b1;
            else begin cnt <= cnt - 4'd1; flag <= 1'b0; end
         end
      end

      always @(posedge Clk or posedge Reset) begin
         if (Reset) m <= model_reset();
         else       m <= model_step(m, D, Start, Stop, SweepTarget, flag);
      end
   end

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic compare_lanes();
      check("l0_mode",   32'(lane[0].udm),  32'(lane[0].m.up));
      check("l0_crst",   32'(lane[0].crst), 32'(lane[0].m.crst));
      check("l0_busy",   32'(lane[0].busy), 32'(lane[0].m.busy));
      check("l0_sweeps", 32'(lane[0].sd),   32'(lane[0].m.sd));
      check("l0_done",   32'(lane[0].done), 32'(lane[0].m.done));
      check("l1_mode",   32'(lane[1].udm),  32'(lane[1].m.up));
      check("l1_crst",   32'(lane[1].crst), 32'(lane[1].m.crst));
      check("l1_busy",   32'(lane[1].busy), 32'(lane[1].m.busy));
      check("l1_sweeps", 32'(lane[1].sd),   32'(lane[1].m.sd));
      check("l1_done",   32'(lane[1].done), 32'(lane[1].m.done));
   endtask

   task automatic tick();
      @(posedge Clk);
      @(negedge Clk);
      compare_lanes();
   endtask

   initial begin
      int         n_done, n_done1, tops, k;
      logic       prev_udm1, found, wrapped, incr_ok;
      logic [7:0] prev_sd1, sd_at_stop;

      Reset = 1'b1; Start = 1'b0; Stop = 1'b0; SweepTarget = 8'd0;
      repeat (2) tick();
      @(negedge Clk);
      Reset = 1'b0;
      check("rst_mode", 32'(lane[0].udm), 0);
      check("rst_crst", 32'(lane[0].crst), 1);
      check("rst_busy", 32'(lane[0].busy), 0);
      check("rst_sweeps", 32'(lane[0].sd), 0);
      check("rst_done", 32'(lane[0].done), 0);
      tick();

      // Basic sweep, target 1; k counts edges from the one sampling Start.
      SweepTarget = 8'd1; Start = 1'b1;
      n_done = 0;
      for (int e = 0; e < 45; e++) begin
         tick();
         Start = 1'b0;
         if (lane[0].done) n_done++;
         case (e)
            0:  begin check("e0_crst", 32'(lane[0].crst), 1); check("e0_busy", 32'(lane[0].busy), 1); end
            1:  begin check("e1_crst", 32'(lane[0].crst), 0); check("e1_mode", 32'(lane[0].udm), 1); end
            16: check("e16_cnt", 32'(lane[0].cnt), 15);
            17: check("e17_flag", 32'(lane[0].flag), 1);
            19: check("e19_mode_dwell", 32'(lane[0].udm), 1);
            20: begin check("e20_mode", 32'(lane[0].udm), 0); check("e20_stale_flag", 32'(lane[0].flag), 1); end
            21: begin check("e21_cnt", 32'(lane[0].cnt), 14); check("e21_sweeps", 32'(lane[0].sd), 0); end
            35: check("e35_cnt", 32'(lane[0].cnt), 0);
            36: begin check("e36_sweeps", 32'(lane[0].sd), 0); check("e36_done", 32'(lane[0].done), 0); end
            37: begin
               check("e37_done", 32'(lane[0].done), 1);
               check("e37_sweeps", 32'(lane[0].sd), 1);
               check("e37_busy", 32'(lane[0].busy), 0);
               check("e37_crst", 32'(lane[0].crst), 1);
            end
            default: ;
         endcase
      end
      check("basic_done_pulses", n_done, 1);

      // Three sweeps without dwell on lane 1.
      SweepTarget = 8'd3; Start = 1'b1;
      tick();
      Start = 1'b0;
      n_done1 = 0; tops = 0; incr_ok = 1'b1;
      prev_udm1 = lane[1].udm; prev_sd1 = lane[1].sd;
      k = 0;
      while ((lane[0].busy || lane[1].busy) && k < 400) begin
         tick();
         k++;
         if (lane[1].done) n_done1++;
         if (prev_udm1 && !lane[1].udm && lane[1].busy) tops++;
         if (lane[1].sd != prev_sd1 && lane[1].sd != prev_sd1 + 8'd1) incr_ok = 1'b0;
         prev_udm1 = lane[1].udm; prev_sd1 = lane[1].sd;
      end
      check("multi_finished", 32'(k < 400), 1);
      check("multi_tops", tops, 3);
      check("multi_done_pulses", n_done1, 1);
      check("multi_sweeps_l1", 32'(lane[1].sd), 3);
      check("multi_sweeps_l0", 32'(lane[0].sd), 3);
      check("multi_incr_by_one", 32'(incr_ok), 1);

      // Stop in the first fall when the counter shows 7.
      SweepTarget = 8'd2; Start = 1'b1;
      tick();
      Start = 1'b0;
      found = 1'b0;
      for (int e = 0; e < 200 && !found; e++) begin
         tick();
         if (lane[0].busy && !lane[0].udm && lane[0].cnt == 4'd7) found = 1'b1;
      end
      check("stop_point_found", 32'(found), 1);
      sd_at_stop = lane[0].sd;
      Stop = 1'b1;
      tick();
      Stop = 1'b0;
      check("stop_busy", 32'(lane[0].busy), 0);
      check("stop_crst", 32'(lane[0].crst), 1);
      check("stop_mode", 32'(lane[0].udm), 0);
      check("stop_sweeps", 32'(lane[0].sd), 32'(sd_at_stop));
      n_done = 0;
      for (int e = 0; e < 5; e++) begin
         tick();
         if (lane[0].done) n_done++;
      end
      check("stop_no_done", n_done, 0);

      // Start with Stop in IDLE is ignored.
      Start = 1'b1; Stop = 1'b1;
      tick();
      Start = 1'b0; Stop = 1'b0;
      tick();
      check("start_stop_idle_l0", 32'(lane[0].busy), 0);
      check("start_stop_idle_l1", 32'(lane[1].busy), 0);

      // Start pulsed during RISE with a different target is ignored.
      SweepTarget = 8'd2; Start = 1'b1;
      tick();
      Start = 1'b0;
      repeat (5) tick();
      SweepTarget = 8'd1; Start = 1'b1;
      tick();
      Start = 1'b0;
      k = 0;
      while (!lane[0].done && k < 300) begin tick(); k++; end
      check("rise_start_done_seen", 32'(lane[0].done), 1);
      check("rise_start_target_kept", 32'(lane[0].sd), 2);
      repeat (3) tick();

      // Target 0: run until lane 1 wraps its sweep count.
      SweepTarget = 8'd0; Start = 1'b1;
      tick();
      Start = 1'b0;
      wrapped = 1'b0; n_done = 0; prev_sd1 = lane[1].sd;
      for (int e = 0; e < 12000 && !wrapped; e++) begin
         tick();
         if (lane[0].done || lane[1].done) n_done++;
         if (prev_sd1 == 8'd255 && lane[1].sd == 8'd0) wrapped = 1'b1;
         prev_sd1 = lane[1].sd;
      end
      check("wrap_seen", 32'(wrapped), 1);
      check("wrap_no_done", n_done, 0);
      check("wrap_still_busy", 32'(lane[1].busy), 1);
      Stop = 1'b1;
      tick();
      Stop = 1'b0;

      // Randomized operation.
      for (int e = 0; e < 4000; e++) begin
         Start       = ($urandom % 8) == 0;
         Stop        = ($urandom % 150) == 0;
         SweepTarget = 8'($urandom % 4);
         tick();
      end
      Start = 1'b0; Stop = 1'b1;
      tick();
      Stop = 1'b0;

      // Asynchronous reset between edges while lane 0 dwells at the top.
      SweepTarget = 8'd1; Start = 1'b1;
      for (int e = 0; e <= 18; e++) begin
         tick();
         Start = 1'b0;
      end
      check("dwell_before_reset_mode", 32'(lane[0].udm), 1);
      check("dwell_before_reset_flag", 32'(lane[0].flag), 1);
      #3 Reset = 1'b1;
      #1;
      check("async_rst_mode", 32'(lane[0].udm), 0);
      check("async_rst_crst", 32'(lane[0].crst), 1);
      check("async_rst_busy", 32'(lane[0].busy), 0);
      check("async_rst_sweeps", 32'(lane[0].sd), 0);
      compare_lanes();
      @(negedge Clk);
      Reset = 1'b0;
      tick();
      SweepTarget = 8'd1; Start = 1'b1;
      tick();
      Start = 1'b0;
      k = 0;
      while (!lane[0].done && k < 100) begin tick(); k++; end
      check("post_reset_done", 32'(lane[0].done), 1);
      check("post_reset_sweeps", 32'(lane[0].sd), 1);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sweep_direction_controller.md
Name: sweep_direction_controller

Overview:
- FSM that drives the UpDownMode input of the up/down counter and consumes its LimitReachedFlag.
- Produces repeated up/down sweeps (triangle profile) between the counter's MIN and MAX, with a programmable dwell at each end.
- Counts completed sweeps and stops after a target number of sweeps, or on Stop.
- Sits directly upstream of the counter; the counter's Output goes to the datapath unchanged.

Parameters:
DWELL_CYCLES, 2, cycles held in each dwell state after a limit is detected; 0 means no dwell states
DWELL_WIDTH, 8, width of the internal dwell counter; DWELL_CYCLES < 2**DWELL_WIDTH
SWEEP_COUNT_WIDTH, 8, width of SweepTarget and SweepsDone

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-high reset
Start  input  1  start request; sampled only in IDLE
Stop  input  1  synchronous abort; highest priority outside IDLE
SweepTarget  input  SWEEP_COUNT_WIDTH  number of full up+down sweeps; 0 means run until Stop; latched on Start
LimitReachedFlag  input  1  from counter
UpDownMode  output  1  to counter; 1 = up, 0 = down (registered)
CounterReset  output  1  to counter's Reset (registered)
Busy  output  1  high in any state other than IDLE
SweepsDone  output  SWEEP_COUNT_WIDTH  completed sweeps; wraps modulo 2**SWEEP_COUNT_WIDTH
Done  output  1  one-cycle pulse on reaching the target

Behaviour:
- Reset values: state IDLE, UpDownMode=0, CounterReset=1, Busy=0, SweepsDone=0, Done=0, Armed=0, dwell counter=0, latched target=0.
- All outputs are registered. Done defaults to 0 every cycle.
- IDLE:
  - CounterReset=1, UpDownMode=0.
  - Start=1 and Stop=0: latch SweepTarget, SweepsDone<=0, Busy<=1, go to CLEAR.
  - Start and Stop both high: remain in IDLE.
- CLEAR: single cycle. Go to RISE with CounterReset<=0, UpDownMode<=1, Armed<=0.
- Armed rule (RISE and FALL):
  - Armed<=1 when LimitReachedFlag is sampled 0.
  - A limit is detected only when Armed=1 and LimitReachedFlag=1.
  - This masks the stale flag, which remains high for one cycle after a direction change.
- RISE:
  - On limit: if DWELL_CYCLES>0, load dwell counter with DWELL_CYCLES-1 and go to DWELL_HIGH.
  - Else go to FALL with UpDownMode<=0, Armed<=0.
- DWELL_HIGH:
  - UpDownMode stays 1; the counter holds at MAX.
  - Dwell counter decrements each cycle; when it is 0, go to FALL with UpDownMode<=0, Armed<=0.
  - The state therefore lasts exactly DWELL_CYCLES cycles.
- FALL: on limit, SweepsDone<=SweepsDone+1.
  - If latched target != 0 and SweepsDone+1 == target: go to IDLE with Done<=1, Busy<=0, CounterReset<=1, UpDownMode<=0.
  - Otherwise go to DWELL_LOW (same dwell rules as DWELL_HIGH), or straight to RISE if DWELL_CYCLES=0.
- DWELL_LOW: UpDownMode stays 0; on expiry go to RISE with UpDownMode<=1, Armed<=0.
- Stop=1 in any non-IDLE state, including the cycle a limit is detected:
  - Go to IDLE with CounterReset<=1, UpDownMode<=0, Busy<=0.
  - No Done pulse; SweepsDone holds its value.
- Start while Busy: ignored. SweepTarget changes while Busy: ignored.
- Target 0: runs indefinitely; SweepsDone wraps from 2**W-1 to 0 without any Done pulse.
- Reset mid-operation: immediate return to reset values; the counter is held in reset via CounterReset=1.

Test Plan:
- Basic sweep:
  - Setup: counter width 4 (MIN 0, MAX 15), DWELL_CYCLES=2, SweepTarget=1, Start sampled at edge E0.
  - Counter Reset deasserts after E1; Output reaches 15 at E16; flag rises at E17.
  - DWELL_HIGH at E18–E20; UpDownMode=0 from E20; Output 14 at E21 and 0 at E35.
  - Done=1 for exactly one cycle after E37; SweepsDone=1; Busy=0; CounterReset=1.
- Stale flag masking: with the same setup, the flag is still 1 at E21 in FALL. The FSM must not count a sweep there; SweepsDone stays 0 until E37.
- Multi-sweep, DWELL_CYCLES=0, SweepTarget=3: exactly three top and three bottom turnarounds; SweepsDone increments 1→2→3; a single Done pulse; no dwell states are visited.
- Stop mid-FALL at Output=7: next cycle IDLE, CounterReset=1, Busy=0, Done never pulses, SweepsDone unchanged.
- Start and Stop together in IDLE: stays IDLE, Busy=0. Start pulsed during RISE: no effect on state or the latched target.
- Asynchronous Reset asserted mid-DWELL_HIGH (between clock edges): outputs take reset values immediately without a clock edge. A later Start then runs a full sweep normally.
